// File: rtl/rip_pseudo_core_burst.sv
// rip_pseudo_core_burst: AXI4 write-then-readback burst traffic generator with error count (RIP_PSEUDO_CORE_LFSR_EN selects LFSR data)
module rip_pseudo_core_burst #(
  parameter int ADDR_WIDTH     = 32,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int BURST_LEN      = 16,
  parameter int NUM_BURSTS     = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [ADDR_WIDTH-1:0]       mem_head,
  output logic [1:0]                  busy,
  output logic                        done,
  output logic [15:0]                 err_cnt,
  output logic [AXI_ID_WIDTH-1:0]     AWID,
  output logic [ADDR_WIDTH-1:0]       AWADDR,
  output logic [7:0]                  AWLEN,
  output logic [2:0]                  AWSIZE,
  output logic [1:0]                  AWBURST,
  output logic                        AWLOCK,
  output logic [3:0]                  AWCACHE,
  output logic [2:0]                  AWPROT,
  output logic [3:0]                  AWQOS,
  output logic [3:0]                  AWREGION,
  output logic                        AWVALID,
  input  logic                        AWREADY,
  output logic [AXI_ID_WIDTH-1:0]     WID,
  output logic [AXI_DATA_WIDTH-1:0]   WDATA,
  output logic [AXI_DATA_WIDTH/8-1:0] WSTRB,
  output logic                        WLAST,
  output logic                        WVALID,
  input  logic                        WREADY,
  input  logic [AXI_ID_WIDTH-1:0]     BID,
  input  logic [1:0]                  BRESP,
  input  logic                        BVALID,
  output logic                        BREADY,
  output logic [AXI_ID_WIDTH-1:0]     ARID,
  output logic [ADDR_WIDTH-1:0]       ARADDR,
  output logic [7:0]                  ARLEN,
  output logic [2:0]                  ARSIZE,
  output logic [1:0]                  ARBURST,
  output logic                        ARLOCK,
  output logic [3:0]                  ARCACHE,
  output logic [2:0]                  ARPROT,
  output logic [3:0]                  ARQOS,
  output logic [3:0]                  ARREGION,
  output logic                        ARVALID,
  input  logic                        ARREADY,
  input  logic [AXI_ID_WIDTH-1:0]     RID,
  input  logic [AXI_DATA_WIDTH-1:0]   RDATA,
  input  logic [1:0]                  RRESP,
  input  logic                        RLAST,
  input  logic                        RVALID,
  output logic                        RREADY
);
  localparam int BYTES   = AXI_DATA_WIDTH / 8;
  localparam int BEAT_W  = $clog2(BURST_LEN) + 1;
  localparam int BURST_W = $clog2(NUM_BURSTS) + 1;
  localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'((64'd1 << $clog2(BURST_LEN * BYTES)) - 64'd1);
  localparam logic [2:0] IDLE = 3'd0, AW = 3'd1, W = 3'd2, B = 3'd3, AR = 3'd4, R = 3'd5, DONE = 3'd6;
  logic [2:0]                st;
  logic [ADDR_WIDTH-1:0]     base, aligned, burst_addr;
  logic [BEAT_W-1:0]         beat;
  logic [BURST_W-1:0]        burst;
  logic                      last_beat, last_burst, hit, unused_ids;
  logic [AXI_DATA_WIDTH-1:0] pat;
  assign aligned    = mem_head & ~LOW_MASK;
  assign burst_addr = base + ADDR_WIDTH'(burst) * ADDR_WIDTH'(BURST_LEN * BYTES);
  assign last_beat  = beat == BEAT_W'(BURST_LEN - 1);
  assign last_burst = burst == BURST_W'(NUM_BURSTS - 1);
  assign unused_ids = ^{BID, RID};
`ifdef RIP_PSEUDO_CORE_LFSR_EN
  logic [31:0] lfsr, lfsr_nxt;
  function automatic logic [31:0] seed_of(input logic [31:0] b);
    seed_of = (b ^ 32'hACE10001) == 32'd0 ? 32'd1 : b ^ 32'hACE10001;
  endfunction
  assign lfsr_nxt = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h80200003 : 32'h0);
  assign pat      = {(AXI_DATA_WIDTH / 32){lfsr_nxt}};
  // Seed on start and again entering the read phase; step once per data beat
  always_ff @(posedge clk)
    if (rst) lfsr <= 32'd1;
    else if (st == IDLE && start) lfsr <= seed_of(32'(aligned));
    else if (st == B && BVALID && last_burst) lfsr <= seed_of(32'(base));
    else if ((st == W && WREADY) || (st == R && RVALID)) lfsr <= lfsr_nxt;
`else
  assign pat = AXI_DATA_WIDTH'(burst_addr + ADDR_WIDTH'(beat) * ADDR_WIDTH'(BYTES));
`endif
  assign hit = (st == B && BVALID && BRESP != 2'b00) ||
               (st == R && RVALID && (RDATA != pat || RRESP != 2'b00 || RLAST != last_beat));
  assign busy     = {st == AR || st == R, st == AW || st == W || st == B};
  assign done     = st == DONE;
  assign AWID     = '0;
  assign AWADDR   = burst_addr;
  assign AWLEN    = 8'(BURST_LEN - 1);
  assign AWSIZE   = 3'($clog2(BYTES));
  assign AWBURST  = 2'b01;
  assign AWLOCK   = 1'b0;
  assign AWCACHE  = 4'b0011;
  assign AWPROT   = '0;
  assign AWQOS    = '0;
  assign AWREGION = '0;
  assign AWVALID  = st == AW;
  assign WID      = AWID;
  assign WDATA    = pat;
  assign WSTRB    = '1;
  assign WLAST    = st == W && last_beat;
  assign WVALID   = st == W;
  assign BREADY   = st == B;
  assign ARID     = '0;
  assign ARADDR   = burst_addr;
  assign ARLEN    = AWLEN;
  assign ARSIZE   = AWSIZE;
  assign ARBURST  = AWBURST;
  assign ARLOCK   = 1'b0;
  assign ARCACHE  = AWCACHE;
  assign ARPROT   = '0;
  assign ARQOS    = '0;
  assign ARREGION = '0;
  assign ARVALID  = st == AR;
  assign RREADY   = st == R;
  // Sequencer: write all bursts, read them back, count faults saturating
  always_ff @(posedge clk)
    if (rst) begin
      st      <= IDLE;
      base    <= '0;
      beat    <= '0;
      burst   <= '0;
      err_cnt <= '0;
    end else begin
      if (hit && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      case (st)
        IDLE: if (start) begin
          base    <= aligned;
          err_cnt <= '0;
          burst   <= '0;
          beat    <= '0;
          st      <= AW;
        end
        AW: if (AWREADY) begin
          beat <= '0;
          st   <= W;
        end
        W: if (WREADY) begin
          beat <= beat + BEAT_W'(1);
          if (last_beat) st <= B;
        end
        B: if (BVALID) begin
          burst <= last_burst ? '0 : burst + BURST_W'(1);
          st    <= last_burst ? AR : AW;
        end
        AR: if (ARREADY) begin
          beat <= '0;
          st   <= R;
        end
        R: if (RVALID) begin
          beat <= beat + BEAT_W'(1);
          if (last_beat) begin
            burst <= last_burst ? '0 : burst + BURST_W'(1);
            st    <= last_burst ? DONE : AR;
          end
        end
        default: st <= IDLE;
      endcase
    end
endmodule
